rs_syndrome_calc: RTL and testbench



---
 rtl/rs_syndrome_calc_if.sv | 24 ++
 rtl/rs_syndrome_calc.sv | 81 ++++++++
 tb/tb_rs_syndrome_calc.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rs_syndrome_calc_if.sv
// rs_syndrome_calc_if: symbol-in / syndrome-out bundle for the RS(31,31-2T) syndrome stage.
//   sym_in[4:0]       received symbol, highest degree first
//   sym_valid         sym_in accepted this cycle
//   sym_sop           first symbol of a block (qualified by sym_valid)
//   syn_out[10*T-1:0] 2T syndromes, S_FCR in [4:0]
//   syn_valid         one-cycle pulse when syn_out updates
//   busy              block partially accumulated
//   err_flag          any syndrome nonzero (only with RS_SYN_ERRFLAG_EN)
interface rs_syndrome_calc_if #(parameter int T = 3);
    logic [4:0]        sym_in;
    logic              sym_valid;
    logic              sym_sop;
    logic [10*T-1:0]   syn_out;
    logic              syn_valid;
    logic              busy;
`ifdef RS_SYN_ERRFLAG_EN
    logic              err_flag;
    modport master (output sym_in, sym_valid, sym_sop, input syn_out, syn_valid, busy, err_flag);
    modport slave  (input sym_in, sym_valid, sym_sop, output syn_out, syn_valid, busy, err_flag);
`else
    modport master (output sym_in, sym_valid, sym_sop, input syn_out, syn_valid, busy);
    modport slave  (input sym_in, sym_valid, sym_sop, output syn_out, syn_valid, busy);
`endif
endinterface

// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc: serial Horner evaluation of r(x) at alpha^FCR..alpha^(FCR+2T-1) over GF(2^5).
//   clock  rising-edge clock
//   reset  asynchronous active-high, clears all state
//   bus    rs_syndrome_calc_if.slave: sym_in/sym_valid/sym_sop in, syn_out/syn_valid/busy out
// Optional macro RS_SYN_ERRFLAG_EN adds bus.err_flag (any syndrome nonzero).
module rs_syndrome_calc #(
    parameter int T   = 3,
    parameter int N   = 31,
    parameter int FCR = 1
) (
    input logic               clock,
    input logic               reset,
    rs_syndrome_calc_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [2*T-1:0][4:0]    acc_q;
    logic [2*T-1:0][4:0]    acc_d;
    logic [2*T-1:0][4:0]    syn_q;
    logic                   syn_valid_q;
`ifdef RS_SYN_ERRFLAG_EN
    logic                   err_q;
    assign bus.err_flag = err_q;
`endif

    // Multiply by alpha^e: e shifts, each folding x^5 back as x^2+1.
    function automatic logic [4:0] mul_alpha(input logic [4:0] a, input int e);
        logic [4:0] r;
        r = a;
        for (int i = 0; i < 31; i++)
            if (i < e % 31) r = {r[3:0], 1'b0} ^ (r[4] ? 5'b00101 : 5'b00000);
        return r;
    endfunction

    for (genvar k = 0; k < 2*T; k++) begin : g_horner
        assign acc_d[k] = mul_alpha(acc_q[k], FCR + k) ^ bus.sym_in;
    end

    assign bus.syn_out   = syn_q;
    assign bus.syn_valid = syn_valid_q;
    assign bus.busy      = (state_q == ACCUM);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            syn_q       <= '0;
            syn_valid_q <= 1'b0;
`ifdef RS_SYN_ERRFLAG_EN
            err_q       <= 1'b0;
`endif
        end else begin
            syn_valid_q <= 1'b0;
            // sop always restarts, abandoning any partial block
            if (bus.sym_valid && bus.sym_sop) begin
                state_q <= ACCUM;
                cnt_q   <= CW'(1);
                acc_q   <= {(2*T){bus.sym_in}};
            end else if (bus.sym_valid && state_q == ACCUM) begin
                acc_q <= acc_d;
                if (cnt_q == LAST) begin
                    syn_q       <= acc_d;
                    syn_valid_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= IDLE;
`ifdef RS_SYN_ERRFLAG_EN
                    err_q       <= |acc_d;
`endif
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// tb_rs_syndrome_calc: table vectors, random blocks vs direct polynomial evaluation, corner sequences.
module tb_rs_syndrome_calc;
    localparam int FCR = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rs_syndrome_calc_if #(.T(3)) bus();
    rs_syndrome_calc #(.T(3), .N(31), .FCR(FCR)) dut (.clock(clock), .reset(reset), .bus(bus));

    int passed = 0;
    int total  = 0;
    int pulses = 0;
    logic [4:0] blk [31];

    always @(posedge clock) if (bus.syn_valid) pulses <= pulses + 1;

    typedef struct {
        string       name;
        int          pos;
        logic [4:0]  val;
        logic [29:0] want;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h", nm, got, want);
    endtask

    function automatic logic [4:0] gmul(input logic [4:0] a, input logic [4:0] b);
        logic [9:0] p;
        p = '0;
        for (int i = 0; i < 5; i++) if (b[i]) p = p ^ (10'(a) << i);
        for (int i = 9; i >= 5; i--) if (p[i]) p = p ^ (10'b100101 << (i - 5));
        return p[4:0];
    endfunction

    function automatic logic [4:0] gpow(input int e);
        logic [4:0] r;
        r = 5'd1;
        for (int i = 0; i < e % 31; i++) r = gmul(r, 5'd2);
        return r;
    endfunction

    // S_j = sum over positions of r_deg * alpha^(j*deg); blk[0] has degree 30
    function automatic logic [29:0] model();
        logic [29:0] s;
        logic [4:0]  a;
        s = '0;
        for (int j = 0; j < 6; j++) begin
            a = '0;
            for (int p = 0; p < 31; p++) a = a ^ gmul(blk[p], gpow((FCR + j) * (30 - p)));
            s[5*j +: 5] = a;
        end
        return s;
    endfunction

    task automatic drive(input logic [4:0] s, input bit sop);
        @(negedge clock);
        bus.sym_in    = s;
        bus.sym_valid = 1'b1;
        bus.sym_sop   = sop;
    endtask

    task automatic idle();
        @(negedge clock);
        bus.sym_valid = 1'b0;
        bus.sym_sop   = 1'b0;
        bus.sym_in    = 5'($urandom);
    endtask

    task automatic send(input int from, input int to, input int gaps);
        int g;
        for (int p = from; p <= to; p++) begin
            g = (gaps > 0) ? int'($urandom_range(gaps, 0)) : 0;
            repeat (g) idle();
            drive(blk[p], p == from);
        end
    endtask

    task automatic expect_done(input string nm, input logic [29:0] want);
        @(negedge clock);
        chk({nm, " valid"}, 32'(bus.syn_valid), 32'd1);
        chk({nm, " syn"}, 32'(bus.syn_out), 32'(want));
`ifdef RS_SYN_ERRFLAG_EN
        chk({nm, " err"}, 32'(bus.err_flag), 32'(want != '0));
`endif
        bus.sym_valid = 1'b0;
        bus.sym_sop   = 1'b0;
        @(negedge clock);
        chk({nm, " one_pulse"}, 32'(bus.syn_valid), 32'd0);
    endtask

    task automatic rand_blk();
        for (int p = 0; p < 31; p++) blk[p] = 5'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int p0;
        logic [29:0] want;
        tbl[0] = '{"zero", 0, 5'h00, 30'h0};
        tbl[1] = '{"deg0", 30, 5'h01, {6{5'h01}}};
        tbl[2] = '{"deg1", 29, 5'h01, {5'b01010, 5'b00101, 5'b10000, 5'b01000, 5'b00100, 5'b00010}};
        tbl[3] = '{"deg0x3", 30, 5'h03, {6{5'h03}}};
        tbl[4] = '{"deg0x1f", 30, 5'h1f, {6{5'h1f}}};
        bus.sym_in = '0;
        bus.sym_valid = 1'b0;
        bus.sym_sop = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset syn", 32'(bus.syn_out), 32'd0);
        chk("reset valid", 32'(bus.syn_valid), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive(5'h1f, 1'b0);
        idle();
        chk("idle drop busy", 32'(bus.busy), 32'd0);
        chk("idle drop valid", 32'(bus.syn_valid), 32'd0);
        for (int v = 0; v < 5; v++) begin
            for (int p = 0; p < 31; p++) blk[p] = '0;
            blk[tbl[v].pos] = tbl[v].val;
            send(0, 30, (v == 2) ? 3 : 0);
            expect_done(tbl[v].name, tbl[v].want);
        end
        for (int p = 0; p < 31; p++) blk[p] = '0;
        blk[30] = 5'h01;
        p0 = pulses;
        send(0, 30, 0);
        @(negedge clock);
        chk("b2b A valid", 32'(bus.syn_valid), 32'd1);
        chk("b2b A syn", 32'(bus.syn_out), 32'({6{5'h01}}));
        bus.sym_in = '0;
        bus.sym_sop = 1'b1;
        bus.sym_valid = 1'b1;
        for (int p = 1; p < 31; p++) begin
            drive(5'h00, 1'b0);
            if (p == 15) begin
                chk("b2b hold syn", 32'(bus.syn_out), 32'({6{5'h01}}));
                chk("b2b busy", 32'(bus.busy), 32'd1);
                chk("b2b pulses mid", 32'(pulses), 32'(p0 + 1));
            end
        end
        expect_done("b2b B", 30'h0);
        chk("b2b pulses", 32'(pulses), 32'(p0 + 2));
        for (int it = 0; it < 6; it++) begin
            rand_blk();
            want = model();
            send(0, 30, (it % 2 == 0) ? 3 : 0);
            expect_done("rand", want);
        end
        rand_blk();
        send(0, 9, 1);
        p0 = pulses;
        rand_blk();
        want = model();
        send(0, 30, 2);
        expect_done("resync", want);
        chk("resync pulses", 32'(pulses), 32'(p0 + 1));
        rand_blk();
        send(0, 14, 0);
        @(negedge clock);
        bus.sym_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midreset syn", 32'(bus.syn_out), 32'd0);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset valid", 32'(bus.syn_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        p0 = pulses;
        rand_blk();
        want = model();
        send(0, 30, 1);
        expect_done("post reset", want);
        repeat (3) idle();
        chk("post reset pulses", 32'(pulses), 32'(p0 + 1));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
